// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back write-allocate cache, 16 x 128-bit lines, single-word CPU port.
module cache_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cpu_req,
   input  logic         cpu_we,
   input  logic [31:0]  cpu_addr,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_ready,
   output logic         cpu_busy,
   output logic         mem_read,
   output logic [31:0]  mem_rd_addr,
   input  logic [127:0] mem_rd_data,
   input  logic         mem_rd_data_valid,
   output logic         mem_write,
   output logic [31:0]  mem_wr_addr,
   output logic [127:0] mem_wr_data,
   input  logic         mem_wr_data_ready
);
   typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_e;
   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic          we_q, we_d, ready_q, ready_d;
   logic [15:0]   valid_q, valid_d, dirty_q, dirty_d;
   logic [127:0]  data_q [16];
   logic [23:0]   tag_q [16];
   logic [23:0]   tag;
   logic [3:0]    idx;
   logic [6:0]    wofs;
   logic [127:0]  line, wline;
   logic          hit, addr_unused;

   assign tag         = addr_q[31:8];
   assign idx         = addr_q[7:4];
   assign wofs        = {addr_q[3:2], 5'd0};
   assign addr_unused = ^addr_q[1:0];
   assign line        = data_q[idx];
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      wline = line;
      wline[wofs +: 32] = wdata_q;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      valid_d = valid_q;
      dirty_d = dirty_q;
      case (state_q)
         IDLE: if (cpu_req) begin
            state_d = COMPARE;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
         end
         COMPARE: if (hit) begin
            state_d = IDLE;
            ready_d = 1'b1;
            if (we_q) dirty_d[idx] = 1'b1;
            else rdata_d = line[wofs +: 32];
         end else begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : ALLOCATE;
         end
         WRITE_BACK: if (mem_wr_data_ready) state_d = ALLOCATE;
         ALLOCATE: if (mem_rd_data_valid) begin
            state_d      = COMPARE;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Arrays are unreset; updates are gated by state, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (state_q == ALLOCATE && mem_rd_data_valid) begin
         data_q[idx] <= mem_rd_data;
         tag_q[idx]  <= tag;
      end else if (state_q == COMPARE && hit && we_q) begin
         data_q[idx] <= wline;
      end
   end

   assign cpu_rdata   = rdata_q;
   assign cpu_ready   = ready_q;
   assign cpu_busy    = state_q != IDLE;
   assign mem_read    = state_q == ALLOCATE;
   assign mem_write   = state_q == WRITE_BACK;
   assign mem_rd_addr = mem_read ? {tag, idx, 4'h0} : '0;
   assign mem_wr_addr = mem_write ? {tag_q[idx], idx, 4'h0} : '0;
   assign mem_wr_data = mem_write ? line : '0;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a line-granular memory responder.
module tb_cache_ctrl;
   logic         clk = 1'b0, rst_n = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0]  cpu_addr = '0, cpu_wdata = '0, cpu_rdata, mem_rd_addr, mem_wr_addr;
   logic         cpu_ready, cpu_busy, mem_read, mem_write;
   logic [127:0] mem_rd_data = '0, mem_wr_data;
   logic         mem_rd_data_valid = 1'b0, mem_wr_data_ready = 1'b0;

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
      .mem_read(mem_read), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_rd_data_valid(mem_rd_data_valid), .mem_write(mem_write), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_data_ready(mem_wr_data_ready)
   );

   always #5 clk = ~clk;

   int           n_chk = 0, n_err = 0;
   int           rd_cnt = 0, wr_cnt = 0, rdy_cnt = 0, dbl_cnt = 0, both_cnt = 0;
   logic [31:0]  last_rd = '0, last_wr = '0;
   logic [127:0] last_wdata = '0;
   logic [127:0] mem [logic [31:0]];
   logic         stall = 1'b0, prev_rdy = 1'b0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'hF;
      return mem.exists(b) ? mem[b] :
         {32'hC000_0000 | b | 32'hC, 32'hC000_0000 | b | 32'h8, 32'hC000_0000 | b | 32'h4, 32'hC000_0000 | b};
   endfunction

   // Memory model answers each handshake in the cycle it is first seen.
   initial forever begin
      @(negedge clk);
      mem_rd_data_valid = 1'b0;
      mem_wr_data_ready = 1'b0;
      if (cpu_ready) begin
         rdy_cnt++;
         if (prev_rdy) dbl_cnt++;
      end
      prev_rdy = cpu_ready;
      if (mem_read && mem_write) both_cnt++;
      if (mem_write) begin
         mem[mem_wr_addr] = mem_wr_data;
         last_wr = mem_wr_addr;
         last_wdata = mem_wr_data;
         wr_cnt++;
         mem_wr_data_ready = 1'b1;
      end else if (mem_read && !stall) begin
         mem_rd_data = line_of(mem_rd_addr);
         last_rd = mem_rd_addr;
         rd_cnt++;
         mem_rd_data_valid = 1'b1;
      end
   end

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] alt, output logic [31:0] rd, output int cyc);
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = a;
      cpu_wdata = d;
      for (cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         if (cpu_ready) break;
         cpu_addr = alt;
      end
      rd = cpu_rdata;
      cpu_req = 1'b0;
   endtask

   task automatic op(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] alt, input logic [31:0] exp_rd, input int exp_cyc);
      logic [31:0] rd;
      int cyc;
      access(we, a, d, alt, rd, cyc);
      check({tag, "_lat"}, cyc, exp_cyc);
      if (!we) check({tag, "_rdata"}, rd, exp_rd);
   endtask

   initial begin
      int rc;
      mem[32'h10] = 128'h44444444_33333333_22222222_11111111;
      repeat (3) @(negedge clk);
      check("rst_ready", cpu_ready, 0);
      check("rst_busy", cpu_busy, 0);
      check("rst_mem_rw", {mem_read, mem_write}, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_addrs", {mem_rd_addr, mem_wr_addr}, 0);
      check("rst_wdata", mem_wr_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      op("cold", 0, 32'h14, 0, 32'h14, 32'h22222222, 4);
      check("cold_rd", {rd_cnt, last_rd}, {32'd1, 32'h10});
      check("cold_wr", wr_cnt, 0);
      op("hit", 0, 32'h14, 0, 32'h14, 32'h22222222, 2);
      check("hit_rd", rd_cnt, 1);
      repeat (2) @(negedge clk);
      check("rdata_hold", cpu_rdata, 32'h22222222);

      op("whit", 1, 32'h18, 32'hDEADBEEF, 32'h18, 0, 2);
      op("rd_after_w", 0, 32'h18, 0, 32'h18, 32'hDEADBEEF, 2);
      op("evict", 0, 32'h118, 0, 32'h118, 32'hC0000118, 5);
      check("evict_wr", {wr_cnt, last_wr}, {32'd1, 32'h10});
      check("evict_word2", last_wdata[95:64], 32'hDEADBEEF);
      check("evict_line", last_wdata, 128'h44444444_DEADBEEF_22222222_11111111);
      check("evict_rd", {rd_cnt, last_rd}, {32'd2, 32'h110});
      op("refetch", 0, 32'h18, 0, 32'h18, 32'hDEADBEEF, 4);
      check("refetch_wr", wr_cnt, 1);

      op("clean_a", 0, 32'h200, 0, 32'h200, 32'hC0000200, 4);
      op("clean_b", 0, 32'h300, 0, 32'h300, 32'hC0000300, 4);
      check("clean_rd", {rd_cnt, last_rd}, {32'd5, 32'h300});
      check("clean_wr", wr_cnt, 1);

      op("busy", 0, 32'h340, 0, 32'h18, 32'hC0000340, 4);
      check("busy_rd", {rd_cnt, last_rd}, {32'd6, 32'h340});
      op("busy_hit", 0, 32'h340, 0, 32'h340, 32'hC0000340, 2);
      op("busy_other", 0, 32'h18, 0, 32'h18, 32'hDEADBEEF, 2);

      op("wmiss", 1, 32'h504, 32'h12345678, 32'h504, 0, 4);
      check("wmiss_rd", {rd_cnt, last_rd}, {32'd7, 32'h500});
      op("wmiss_evict", 0, 32'h604, 0, 32'h604, 32'hC0000604, 5);
      check("wmiss_wr", {wr_cnt, last_wr}, {32'd2, 32'h500});
      check("wmiss_line", last_wdata, 128'hC000050C_C0000508_12345678_C0000500);

      stall = 1'b1;
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 32'h424;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_read) break;
      end
      cpu_req = 1'b0;
      check("fill_start", {mem_read, mem_rd_addr}, {1'b1, 32'h420});
      rc = rdy_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_read", {mem_read, mem_rd_addr}, 0);
      check("abort_busy", cpu_busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      check("abort_no_ready", rdy_cnt, rc);
      check("abort_rdata", cpu_rdata, 0);
      op("after_abort", 0, 32'h424, 0, 32'h424, 32'hC0000424, 4);
      check("after_abort_rd", {rd_cnt, last_rd}, {32'd9, 32'h420});
      op("cold_again", 0, 32'h14, 0, 32'h14, 32'h22222222, 4);
      check("cold_again_rd", rd_cnt, 10);

      check("ready_twice", dbl_cnt, 0);
      check("rd_wr_both", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
